// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for a 16-bit single-issue datapath: fetches over a
// req/ack handshake, decodes from the instruction register, resolves BEQ on Zero.
module control_sequencer (
    input  logic        CLK,
    input  logic        RST,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_ack,
    input  logic [15:0] instr,
    input  logic        Zero,
    output logic [3:0]  RA1,
    output logic [3:0]  RA2,
    output logic [3:0]  WA,
    output logic [7:0]  immediate,
    output logic        write_enable,
    output logic        ALUsrc,
    output logic [1:0]  ALUControl,
    output logic        halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa;
        logic [7:0] imm;
        logic       src;
        logic [1:0] ctl;
    } dec_t;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    dec_t        dec;

    logic [3:0] op, f1, f2, f3;
    logic [7:0] br_off;

    assign op     = ir[15:12];
    assign f1     = ir[11:8];
    assign f2     = ir[7:4];
    assign f3     = ir[3:0];
    assign br_off = {{4{f3[3]}}, f3};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_FETCH;
            pc    <= 8'h00;
            ir    <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: if (instr_ack) begin
                    ir    <= instr;
                    pc    <= pc + 8'd1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= (op == 4'hF) ? S_HALT : S_FETCH;
                    // pc already points past the branch, so the offset is relative to it
                    if (op == 4'h8 && Zero)
                        pc <= pc + br_off;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        dec = '0;
        if (!op[3]) begin
            dec.wa  = f1;
            dec.ctl = op[1:0];
            if (!op[2]) begin
                dec.ra1 = f2;
                dec.ra2 = f3;
            end else begin
                dec.ra1 = f1;
                dec.imm = ir[7:0];
                dec.src = 1'b1;
            end
        end else if (op == 4'h8) begin
            dec.ra1 = f1;
            dec.ra2 = f2;
            dec.ctl = 2'b01;
        end
    end

    assign RA1          = dec.ra1;
    assign RA2          = dec.ra2;
    assign WA           = dec.wa;
    assign immediate    = dec.imm;
    assign ALUsrc       = dec.src;
    assign ALUControl   = dec.ctl;
    assign instr_addr   = pc;
    // state is FETCH during reset, so the request is held off explicitly
    assign instr_req    = (state == S_FETCH) && !RST;
    assign write_enable = (state == S_EXEC) && !op[3];
    assign halted       = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of single-instruction vectors
// walked from reset, plus hand sequences for HALT and mid-instruction reset.
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_ack = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        Zero = 1'b0;
    logic [3:0]  RA1, RA2, WA;
    logic [7:0]  immediate;
    logic        write_enable, ALUsrc, halted;
    logic [1:0]  ALUControl;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer dut (
        .CLK(CLK), .RST(RST),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr(instr), .Zero(Zero),
        .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate),
        .write_enable(write_enable), .ALUsrc(ALUsrc),
        .ALUControl(ALUControl), .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        int          stall;
        logic [7:0]  addr;
        logic [3:0]  ra1, ra2, wa;
        logic [7:0]  imm;
        logic        src;
        logic [1:0]  ctl;
        logic        we;
        logic [7:0]  nxt;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT in FETCH.
    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        chk($sformatf("v%0d req", i), instr_req, 1'b1);
        chk($sformatf("v%0d addr", i), instr_addr, v.addr);
        for (int s = 0; s < v.stall; s++) begin
            instr_ack = 1'b0;
            tick();
            chk($sformatf("v%0d stall%0d req", i, s), instr_req, 1'b1);
            chk($sformatf("v%0d stall%0d addr", i, s), instr_addr, v.addr);
            chk($sformatf("v%0d stall%0d we", i, s), write_enable, 1'b0);
        end
        instr_ack = 1'b1;
        instr     = v.ins;
        tick();
        instr_ack = 1'b0;
        Zero      = v.z;
        #1;
        chk($sformatf("v%0d exec req", i), instr_req, 1'b0);
        chk($sformatf("v%0d RA1", i), RA1, v.ra1);
        chk($sformatf("v%0d RA2", i), RA2, v.ra2);
        chk($sformatf("v%0d WA", i), WA, v.wa);
        chk($sformatf("v%0d imm", i), immediate, v.imm);
        chk($sformatf("v%0d ALUsrc", i), ALUsrc, v.src);
        chk($sformatf("v%0d ALUControl", i), ALUControl, v.ctl);
        chk($sformatf("v%0d we", i), write_enable, v.we);
        tick();
        chk($sformatf("v%0d next addr", i), instr_addr, v.nxt);
        chk($sformatf("v%0d next we", i), write_enable, 1'b0);
        Zero = 1'b0;
    endtask

    initial begin
        //            ins      z  st addr   ra1   ra2   wa    imm    src  ctl   we   nxt
        tbl[0]  = '{16'h0312, 0, 0, 8'h00, 4'h1, 4'h2, 4'h3, 8'h00, 0, 2'b00, 1, 8'h01};
        tbl[1]  = '{16'h65F0, 0, 0, 8'h01, 4'h5, 4'h0, 4'h5, 8'hF0, 1, 2'b10, 1, 8'h02};
        tbl[2]  = '{16'h1ABC, 0, 3, 8'h02, 4'hB, 4'hC, 4'hA, 8'h00, 0, 2'b01, 1, 8'h03};
        tbl[3]  = '{16'h7C81, 1, 0, 8'h03, 4'hC, 4'h0, 4'hC, 8'h81, 1, 2'b11, 1, 8'h04};
        tbl[4]  = '{16'h8127, 1, 0, 8'h04, 4'h1, 4'h2, 4'h0, 8'h00, 0, 2'b01, 0, 8'h0C};
        tbl[5]  = '{16'h8343, 1, 0, 8'h0C, 4'h3, 4'h4, 4'h0, 8'h00, 0, 2'b01, 0, 8'h10};
        tbl[6]  = '{16'h812E, 1, 0, 8'h10, 4'h1, 4'h2, 4'h0, 8'h00, 0, 2'b01, 0, 8'h0F};
        tbl[7]  = '{16'h812E, 0, 0, 8'h0F, 4'h1, 4'h2, 4'h0, 8'h00, 0, 2'b01, 0, 8'h10};
        tbl[8]  = '{16'h9ABC, 1, 0, 8'h10, 4'h0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 8'h11};
        tbl[9]  = '{16'h8568, 1, 0, 8'h11, 4'h5, 4'h6, 4'h0, 8'h00, 0, 2'b01, 0, 8'h0A};
        tbl[10] = '{16'h8008, 1, 0, 8'h0A, 4'h0, 4'h0, 4'h0, 8'h00, 0, 2'b01, 0, 8'h03};
        tbl[11] = '{16'h800A, 1, 0, 8'h03, 4'h0, 4'h0, 4'h0, 8'h00, 0, 2'b01, 0, 8'hFE};
        tbl[12] = '{16'h8127, 1, 0, 8'hFE, 4'h1, 4'h2, 4'h0, 8'h00, 0, 2'b01, 0, 8'h06};
        tbl[13] = '{16'h2DEF, 0, 2, 8'h06, 4'hE, 4'hF, 4'hD, 8'h00, 0, 2'b10, 1, 8'h07};
        tbl[14] = '{16'hE123, 1, 0, 8'h07, 4'h0, 4'h0, 4'h0, 8'h00, 0, 2'b00, 0, 8'h08};

        // reset state
        #12;
        chk("rst req", instr_req, 1'b0);
        chk("rst addr", instr_addr, 8'h00);
        chk("rst we", write_enable, 1'b0);
        chk("rst halted", halted, 1'b0);
        chk("rst decode", {RA1, RA2, WA, immediate, ALUsrc, ALUControl}, 23'h0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #1;

        for (int i = 0; i < 15; i++) run_vec(i);

        // HALT at 0x08; ack held high afterwards must be ignored
        chk("halt fetch addr", instr_addr, 8'h08);
        instr_ack = 1'b1;
        instr     = 16'hF000;
        tick();
        instr = 16'h0312;
        chk("halt exec we", write_enable, 1'b0);
        chk("halt exec req", instr_req, 1'b0);
        chk("halt exec decode", {RA1, RA2, WA, immediate, ALUsrc, ALUControl}, 23'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("halted c%0d", c), halted, 1'b1);
            chk($sformatf("halt req c%0d", c), instr_req, 1'b0);
            chk($sformatf("halt we c%0d", c), write_enable, 1'b0);
        end
        instr_ack = 1'b0;

        // async reset out of HALT, mid-cycle
        #2 RST = 1'b1;
        #1;
        chk("halt rst halted", halted, 1'b0);
        chk("halt rst req", instr_req, 1'b0);
        chk("halt rst addr", instr_addr, 8'h00);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("rel req", instr_req, 1'b1);
        chk("rel addr", instr_addr, 8'h00);

        // reset during EXEC of an R-type drops write_enable immediately
        instr_ack = 1'b1;
        instr     = 16'h0312;
        tick();
        instr_ack = 1'b0;
        chk("pre-rst we", write_enable, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("exec rst we", write_enable, 1'b0);
        chk("exec rst WA", WA, 4'h0);
        chk("exec rst req", instr_req, 1'b0);
        chk("exec rst addr", instr_addr, 8'h00);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("post-rst req", instr_req, 1'b1);
        chk("post-rst addr", instr_addr, 8'h00);
        tick();
        chk("post-rst idle we", write_enable, 1'b0);
        chk("post-rst idle addr", instr_addr, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
